frame_fill: RTL and testbench
=============================

# frame_fill

Back-buffer writer that sits directly upstream of the frame controller's write interface. It accepts a pixel stream through a valid/ready handshake and writes it linearly into the frame currently owned by the write side. After the last word of a frame it requests a buffer flip, then stalls the stream until the flip is granted. Optionally, it clears the new back buffer to a constant before resuming.

## Interface
- FRAME_WORDS, 65536: words per frame; legal range 2..2^ADR_W.
- ADR_W, 16: address width.
- DATA_W, 9: pixel width.
- iClk  in  1  single clock; all state changes on the rising edge.
- iRst  in  1  asynchronous, active-high reset.
- iPixValid  in  1  upstream pixel valid.
- iPix  in  DATA_W  pixel data.
- oPixReady  out  1  block can accept a pixel this cycle.
- iClrReq  in  1  one-cycle pulse: clear the next back buffer after the next flip.
- iClrVal  in  DATA_W  clear value, sampled on entry to CLEAR.
- iFlipGo  in  1  flip grant (vertical-blank window) from display timing.
- oFlip  out  1  flip request to the frame controller; the flip occurs on any edge with oFlip && iFlipGo.
- oAdr  out  ADR_W  write address to the frame controller write port.
- oD  out  DATA_W  write data.
- oWrEn  out  1  write strobe.
- oFrameCnt  out  8  completed-flip counter; wraps 255 -> 0.
- oBusy  out  1  high in DRAIN, FLIP_REQ or CLEAR.

## Operation
- States: FILL, DRAIN, FLIP_REQ, CLEAR.
- Reset values (asynchronous):
  - state = FILL
  - address counter = 0
  - clear latch = 0
  - oWrEn = 0, oAdr = 0, oD = 0, oFlip = 0, oFrameCnt = 0
  - oPixReady = 0 during reset, then 1 in the first cycle after reset release.
- FILL:
  - oPixReady = 1.
  - An accepted pixel (iPixValid && oPixReady at the edge) registers oAdr = counter, oD = iPix, oWrEn = 1 for exactly one cycle, then increments the counter.
  - If the accepted pixel had counter == FRAME_WORDS-1, the counter returns to 0, state -> DRAIN, and oPixReady drops in the next cycle.
- DRAIN:
  - Lasts one cycle so the final write lands before the flip request.
  - oWrEn = 1 for the final write; oPixReady = 0.
  - Then -> FLIP_REQ.
- FLIP_REQ:
  - oFlip = 1 (registered); oPixReady = 0; oWrEn = 0.
  - On an edge with iFlipGo = 1: oFlip -> 0 and oFrameCnt += 1.
  - If the clear latch is set, clear the latch and go to CLEAR; otherwise go to FILL.
  - oFlip is held indefinitely while iFlipGo = 0.
- CLEAR:
  - iClrVal is captured on entry.
  - One write per cycle: oAdr = 0..FRAME_WORDS-1, oD = captured value, oWrEn = 1 continuously; oPixReady = 0.
  - After address FRAME_WORDS-1 is issued -> FILL with counter = 0.
- Clear latch:
  - Set by iClrReq in any state, including CLEAR, where it applies after the following flip.
  - Cleared only on consumption at a flip grant.
  - A request arriving in the same cycle as a grant counts as already latched.
- iFlipGo is ignored outside FLIP_REQ.
- iPixValid is ignored while oPixReady = 0; pixels are never dropped or duplicated.
- Address arithmetic: an unsigned ADR_W-bit counter compared against FRAME_WORDS-1. No write is ever issued at an address >= FRAME_WORDS.

## Timing
- Pixel accepted at edge N -> oWrEn/oAdr/oD valid from edge N to N+1; one-cycle latency, one write per accepted pixel.
- Full-rate streaming sustains 1 pixel/cycle in FILL.
- Last pixel at edge N:
  - write visible N..N+1
  - oPixReady = 0 from N
  - oFlip = 1 from N+1
- Grant at edge G:
  - oFlip = 0 from G.
  - Without clear: oPixReady = 1 from G.
  - With clear: CLEAR writes occupy G..G+FRAME_WORDS, and oPixReady = 1 from G+FRAME_WORDS.
- Minimum frame period is FRAME_WORDS + 2 cycles without clear.
- Reset asserted mid-frame or mid-CLEAR: outputs drop immediately and asynchronously; no partial write strobe survives. The frame restarts at address 0 with oFrameCnt = 0.

## Test plan
- FRAME_WORDS=16, continuous valid, pixels 0..15, iFlipGo=0 -> 16 writes with oAdr 0..15, oD = pixel, oFlip = 1 one cycle after the last write and held, oPixReady = 0.
- Same as above, then a one-cycle iFlipGo pulse -> oFlip drops, oFrameCnt = 1, the next pixel is written at oAdr = 0.
- Random iPixValid gaps (50%) over 3 frames, flip granted 5 cycles after each request -> write sequence equals the accepted pixel sequence, addresses 0..15 per frame, oFrameCnt = 3.
- iClrReq pulsed mid-frame with iClrVal = 9'h1A5 -> after the grant, 16 consecutive writes of 9'h1A5 at 0..15 with oPixReady = 0, then FILL resumes at 0; the following flip does not clear.
- Assert iRst at pixel 7 and during CLEAR at address 4 -> oWrEn/oFlip/oFrameCnt are 0 immediately, and the next accepted pixel is written at oAdr = 0.
- 256 flips -> oFrameCnt wraps to 0; an iFlipGo pulse during FILL has no effect.

Source files
------------

// File: rtl/frame_fill.sv
// Back-buffer writer: streams pixels linearly into the write-side frame, requests a flip per frame
// and optionally clears the new back buffer. One-cycle write latency; oPixReady low while busy.
module frame_fill #(
  parameter int FRAME_WORDS = 65536,
  parameter int ADR_W       = 16,
  parameter int DATA_W      = 9
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iPixValid,
  input  logic [DATA_W-1:0] iPix,
  output logic              oPixReady,
  input  logic              iClrReq,
  input  logic [DATA_W-1:0] iClrVal,
  input  logic              iFlipGo,
  output logic              oFlip,
  output logic [ADR_W-1:0]  oAdr,
  output logic [DATA_W-1:0] oD,
  output logic              oWrEn,
  output logic [7:0]        oFrameCnt,
  output logic              oBusy
);

  typedef enum logic [1:0] {FILL, DRAIN, FLIP_REQ, CLEAR} state_t;

  localparam logic [ADR_W-1:0] LAST = ADR_W'(FRAME_WORDS - 1);

  state_t            state;
  logic [ADR_W-1:0]  cnt;
  logic              clr_latch;
  logic [DATA_W-1:0] clr_val;
  logic              accept;

  assign accept = iPixValid && oPixReady;
  assign oBusy  = (state != FILL);

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state     <= FILL;
      cnt       <= '0;
      clr_latch <= 1'b0;
      clr_val   <= '0;
      oPixReady <= 1'b0;
      oFlip     <= 1'b0;
      oAdr      <= '0;
      oD        <= '0;
      oWrEn     <= 1'b0;
      oFrameCnt <= '0;
    end else begin
      // A request in the grant cycle is consumed by the grant below (later assignment wins).
      if (iClrReq) clr_latch <= 1'b1;
      case (state)
        FILL: begin
          oWrEn <= accept;
          if (accept) begin
            oAdr <= cnt;
            oD   <= iPix;
            if (cnt == LAST) begin
              cnt       <= '0;
              state     <= DRAIN;
              oPixReady <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            oPixReady <= 1'b1;
          end
        end
        DRAIN: begin
          oWrEn <= 1'b0;
          oFlip <= 1'b1;
          state <= FLIP_REQ;
        end
        FLIP_REQ: begin
          oWrEn <= 1'b0;
          if (iFlipGo) begin
            oFlip     <= 1'b0;
            oFrameCnt <= oFrameCnt + 8'd1;
            clr_latch <= 1'b0;
            if (clr_latch || iClrReq) begin
              state   <= CLEAR;
              clr_val <= iClrVal;
              oAdr    <= '0;
              oD      <= iClrVal;
              oWrEn   <= 1'b1;
              cnt     <= ADR_W'(1);
            end else begin
              state     <= FILL;
              oPixReady <= 1'b1;
            end
          end
        end
        CLEAR: begin
          // The write to the last address was issued on the previous edge.
          if (oAdr == LAST) begin
            oWrEn     <= 1'b0;
            oPixReady <= 1'b1;
            state     <= FILL;
          end else begin
            oAdr  <= cnt;
            oD    <= clr_val;
            oWrEn <= 1'b1;
            cnt   <= (cnt == LAST) ? '0 : cnt + 1'b1;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_fill.sv
// Randomized/directed bench for frame_fill (FRAME_WORDS=16) against a frame-level reference model.
module tb_frame_fill;

  localparam int FW = 16;

  logic       iClk = 1'b0;
  logic       iRst;
  logic       iPixValid;
  logic [8:0] iPix;
  logic       oPixReady;
  logic       iClrReq;
  logic [8:0] iClrVal;
  logic       iFlipGo;
  logic       oFlip;
  logic [3:0] oAdr;
  logic [8:0] oD;
  logic       oWrEn;
  logic [7:0] oFrameCnt;
  logic       oBusy;

  frame_fill #(.FRAME_WORDS(FW), .ADR_W(4), .DATA_W(9)) dut (
    .iClk(iClk), .iRst(iRst), .iPixValid(iPixValid), .iPix(iPix), .oPixReady(oPixReady),
    .iClrReq(iClrReq), .iClrVal(iClrVal), .iFlipGo(iFlipGo), .oFlip(oFlip), .oAdr(oAdr),
    .oD(oD), .oWrEn(oWrEn), .oFrameCnt(oFrameCnt), .oBusy(oBusy)
  );

  always #5 iClk = ~iClk;

  int checks = 0;
  int errors = 0;

  // Reference model: pixels accepted since reset, flips granted, pending clear, clear cycles left.
  logic [12:0] expq[$];
  int total, flips, clr_left, flip_age;
  bit waiting, drain, clr_pend;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge iClk) begin
    if (!iRst && oWrEn === 1'b1) begin
      if (expq.size() == 0) begin
        chk("wr_unexpected", 32'(oWrEn), 32'd0);
      end else begin
        logic [12:0] e;
        e = expq.pop_front();
        chk("wr_adr", 32'(oAdr), 32'(e[12:9]));
        chk("wr_dat", 32'(oD), 32'(e[8:0]));
      end
    end
  end

  task automatic reset_body();
    iRst = 1'b1; iPixValid = 1'b0; iFlipGo = 1'b0; iClrReq = 1'b0;
    #1;
    chk("rst_wren", 32'(oWrEn), 32'd0);
    chk("rst_flip", 32'(oFlip), 32'd0);
    chk("rst_fcnt", 32'(oFrameCnt), 32'd0);
    chk("rst_rdy", 32'(oPixReady), 32'd0);
    chk("rst_adr", 32'(oAdr), 32'd0);
    chk("rst_busy", 32'(oBusy), 32'd0);
    expq.delete();
    total = 0; flips = 0; clr_left = 0; flip_age = 0;
    waiting = 0; drain = 0; clr_pend = 0;
    @(negedge iClk);
    @(negedge iClk);
    iRst = 1'b0;
    #1;
    chk("rel_rdy", 32'(oPixReady), 32'd0);
    @(negedge iClk);
  endtask

  // Checks outputs at the current negedge, drives inputs for the next edge, advances the model.
  task automatic cycle(input bit v, input logic [8:0] p, input bit go, input bit clr,
                       input logic [8:0] cv, input bit rst_after);
    bit exp_rdy, exp_flip, acc, grant;
    exp_rdy  = !waiting && clr_left == 0;
    exp_flip = waiting && !drain;
    chk("pix_ready", 32'(oPixReady), 32'(exp_rdy));
    chk("flip", 32'(oFlip), 32'(exp_flip));
    chk("frame_cnt", 32'(oFrameCnt), 32'(flips % 256));
    chk("busy", 32'(oBusy), 32'(waiting || clr_left > 0));
    iPixValid = v; iPix = p; iFlipGo = go; iClrReq = clr; iClrVal = cv;
    acc   = v && exp_rdy;
    grant = go && exp_flip;
    if (clr_left > 0) clr_left--;
    drain = 0;
    if (exp_flip) flip_age++;
    if (acc) begin
      expq.push_back({4'(total % FW), p});
      total++;
      if (total % FW == 0) begin
        waiting = 1; drain = 1; flip_age = 0;
      end
    end
    if (grant) begin
      waiting = 0;
      flips++;
      if (clr_pend || clr) begin
        clr_pend = 0;
        clr_left = FW;
        for (int i = 0; i < FW; i++) expq.push_back({4'(i), cv});
      end
    end else if (clr) begin
      clr_pend = 1;
    end
    if (rst_after) begin
      @(posedge iClk);
      #1;
      reset_body();
    end else begin
      @(negedge iClk);
    end
  endtask

  task automatic run_frames(input int n, input int pct, input int delay, input int go_noise,
                            input int clr_pct, input bit rand_cv);
    int target;
    bit go;
    target = flips + n;
    for (int c = 0; c < n * 80 + 100 && flips < target; c++) begin
      if (waiting && !drain) go = (flip_age >= delay);
      else go = ($urandom_range(99) < go_noise);
      cycle($urandom_range(99) < pct, 9'($urandom), go, $urandom_range(99) < clr_pct,
            rand_cv ? 9'($urandom) : 9'h1A5, 1'b0);
    end
    chk("run_done", 32'(flips >= target), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    iRst = 1'b1; iPixValid = 1'b0; iPix = '0; iClrReq = 1'b0; iClrVal = 9'h1A5; iFlipGo = 1'b0;
    reset_body();

    // One full frame at full rate, no grant: flip raised and held, ready low.
    for (int i = 0; i < FW; i++) cycle(1, 9'(i), 0, 0, 9'h1A5, 0);
    for (int i = 0; i < 6; i++) cycle(1, 9'h0FF, 0, 0, 9'h1A5, 0);
    cycle(0, 9'h000, 1, 0, 9'h1A5, 0);
    chk("fcnt_one", 32'(oFrameCnt), 32'd1);

    // Reset while pixel 7's write strobe is up.
    for (int i = 0; i < 8; i++) cycle(1, 9'(100 + i), 0, 0, 9'h1A5, i == 7);
    cycle(1, 9'h055, 0, 0, 9'h1A5, 0);

    // Gappy stream over three frames, grant a few cycles after each request.
    run_frames(3, 50, 4, 0, 0, 0);
    chk("fcnt_three", 32'(oFrameCnt), 32'd3);

    // Clear requested mid-frame: next grant clears, the one after does not.
    for (int i = 0; i < 6; i++) cycle(1, 9'($urandom), 0, i == 2, 9'h1A5, 0);
    run_frames(1, 100, 2, 0, 0, 0);
    chk("clr_wren", 32'(oWrEn), 32'd1);
    chk("clr_adr0", 32'(oAdr), 32'd0);
    chk("clr_dat0", 32'(oD), 32'h1A5);
    run_frames(1, 100, 2, 0, 0, 0);
    chk("noclr_rdy", 32'(oPixReady), 32'd1);
    chk("noclr_wren", 32'(oWrEn), 32'd0);

    // Reset in the middle of a clear, while address 4 is being written.
    cycle(1, 9'($urandom), 0, 1, 9'h1A5, 0);
    run_frames(1, 100, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) cycle(0, 9'h000, 0, 0, 9'h1A5, k == 4);
    cycle(1, 9'h0AA, 0, 0, 9'h1A5, 0);

    // Counter wrap with stray grants outside the request window and occasional clears.
    run_frames(256, 100, 0, 5, 2, 1);
    chk("fcnt_wrap", 32'(oFrameCnt), 32'd0);

    for (int i = 0; i < 20; i++) cycle(0, 9'h000, 0, 0, 9'h1A5, 0);
    chk("wr_leftover", 32'(expq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
